bit_serializer: RTL

Parallel-to-serial front end for the overlapping sequence-detector stage. Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on `x_out`, which drives the detector's serial input `x` directly. Back-to-back words stream without bubbles. `x_out` is held at 0 while idle, so the detector sees a clean zero stream between words.

---
 rtl/seq_pkg.sv | 19 +
 rtl/bit_serializer.sv | 103 ++++++++++
 2 files changed

// File: rtl/seq_pkg.sv
// ============================================================================
// seq_pkg
// Shared types and defaults for the serializer / sequence-detector slice.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_pkg;

  typedef enum logic [0:0] {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_t;

  localparam int SER_DEF_WIDTH = 8;

endpackage : seq_pkg

`default_nettype wire

// File: rtl/bit_serializer.sv
// ============================================================================
// bit_serializer
// Parallel-to-serial front end feeding the sequence detector's serial input.
// Optional macro SER_LSB_FIRST_EN selects LSB-first order (default MSB first).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH = SER_DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

  ser_state_t       r_state;
  logic [WIDTH-1:0] r_sreg;
  logic [CW-1:0]    r_cnt;

  ser_state_t       w_next_state;
  logic [WIDTH-1:0] w_next_sreg;
  logic [CW-1:0]    w_next_cnt;
  logic [WIDTH-1:0] w_shifted;
  logic             w_in_ready;

  // Zero fill keeps the register clear once a word has fully drained,
  // so x_out is 0 in idle straight from the flop.
`ifdef SER_LSB_FIRST_EN
  assign w_shifted = {1'b0, r_sreg[WIDTH-1:1]};
  assign x_out     = r_sreg[0];
`else
  assign w_shifted = {r_sreg[WIDTH-2:0], 1'b0};
  assign x_out     = r_sreg[WIDTH-1];
`endif

  always_comb begin
    w_next_state = r_state;
    w_next_sreg  = r_sreg;
    w_next_cnt   = r_cnt;
    w_in_ready   = 1'b0;
    case (r_state)
      SER_IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_next_sreg  = in_data;
          w_next_cnt   = '0;
          w_next_state = SER_SHIFT;
        end
      end
      SER_SHIFT: begin
        if (r_cnt == c_last) begin
          w_in_ready = 1'b1;
          if (in_valid) begin
            w_next_sreg = in_data;
            w_next_cnt  = '0;
          end else begin
            w_next_sreg  = w_shifted;
            w_next_cnt   = '0;
            w_next_state = SER_IDLE;
          end
        end else begin
          w_next_sreg = w_shifted;
          w_next_cnt  = r_cnt + CW'(1);
        end
      end
      default: begin
        w_next_state = SER_IDLE;
        w_next_sreg  = '0;
        w_next_cnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SER_IDLE;
      r_sreg  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_sreg  <= w_next_sreg;
      r_cnt   <= w_next_cnt;
    end
  end

  assign in_ready = w_in_ready;
  assign x_valid  = (r_state == SER_SHIFT);
  assign busy     = (r_state == SER_SHIFT);

endmodule : bit_serializer

`default_nettype wire
